// File: rtl/ferq_pkg.sv
// Shared constants and types for the UART command controller of the
// frequency/spike design: framing bytes, command codes, register reset
// defaults and the controller state encoding.
package ferq_pkg;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;

  localparam logic [7:0] CMD_WR_PERIOD = 8'h01;
  localparam logic [7:0] CMD_WR_WIDTH  = 8'h02;
  localparam logic [7:0] CMD_WR_ENABLE = 8'h03;
  localparam logic [7:0] CMD_RD_PERIOD = 8'h81;
  localparam logic [7:0] CMD_RD_WIDTH  = 8'h82;

  localparam logic [15:0] PERIOD_RST = 16'd1000;
  localparam logic [15:0] WIDTH_RST  = 16'd500;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_CMD = 3'd1,
    S_GET_DH  = 3'd2,
    S_GET_DL  = 3'd3,
    S_GET_CHK = 3'd4,
    S_EXEC    = 3'd5,
    S_TX_LOAD = 3'd6,
    S_TX_WAIT = 3'd7
  } state_t;

  // Frame checksum: XOR of the three payload bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] dh,
                                           input logic [7:0] dl);
    return cmd ^ dh ^ dl;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter. Counts while enabled, restarts on clear.
// expire is combinational so the controller can register frame_err in the
// following cycle, landing exactly FRAME_TO cycles after the last clear.
module frame_timer #(
  parameter int FRAME_TO = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(FRAME_TO);

  logic [CW-1:0] cnt;

  // Counter: clear has priority so a byte arriving on the timeout cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The count is about to reach FRAME_TO-1 and no byte arrived this cycle.
  assign expire = en && !clr && (cnt == CW'(FRAME_TO - 2));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses A5/CMD/DH/DL/CHK frames, updates the spike
// configuration registers and streams an ACK/NACK reply through uart_send.
// Handshake with uart_send: tx_en is a one-cycle request issued only when
// tx_busy was sampled low; tx_busy is ignored for two cycles after a request
// (the sender needs that long to raise it), then must drop before the next.
module uart_cmd_ctrl
  import ferq_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int FRAME_TO = CLK_FREQ / 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [15:0] spk_period,
  output logic [15:0] spk_width,
  output logic        spk_enable,
  output logic        cfg_update,
  output logic        frame_err,
  output state_t      dbg_state
);

  state_t          state, state_nxt;
  logic [7:0]      cmd_q, dh_q, dl_q, chk_q;
  logic [7:0]      cmd_d, dh_d, dl_d, chk_d;
  logic [3:0][7:0] reply_q, reply_d;
  logic [2:0]      rcnt_q, rcnt_d, ridx_q, ridx_d;
  logic [1:0]      hold_q, hold_d;
  logic [15:0]     per_d, wid_d;
  logic            ena_d, tx_en_d, cfg_d, err_d;
  logic [7:0]      tx_data_d;

  logic        expire, in_get, load;
  logic        chk_ok, accept, is_read, wr_per, wr_wid, wr_ena;
  logic [15:0] value, rd_val;
  logic [7:0]  first_byte;

  assign dbg_state  = state;
  assign in_get     = (state == S_GET_CMD) || (state == S_GET_DH) ||
                      (state == S_GET_DL)  || (state == S_GET_CHK);
  assign load       = !tx_busy && (((state == S_EXEC) && chk_ok) || (state == S_TX_LOAD));
  assign first_byte = accept ? ACK : NACK;

  frame_timer #(.FRAME_TO(FRAME_TO)) u_timer (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clr    (rx_done || !in_get),
    .en     (in_get),
    .expire (expire)
  );

  // Decode the captured frame against the current register values.
  always_comb begin
    value   = {dh_q, dl_q};
    chk_ok  = (chk_q == frame_chk(cmd_q, dh_q, dl_q));
    accept  = 1'b0;
    is_read = 1'b0;
    wr_per  = 1'b0;
    wr_wid  = 1'b0;
    wr_ena  = 1'b0;
    rd_val  = 16'd0;
    case (cmd_q)
      CMD_WR_PERIOD: begin
        wr_per = (value >= 16'd2) && (value > spk_width);
        accept = wr_per;
      end
      CMD_WR_WIDTH: begin
        wr_wid = (value != 16'd0) && (value < spk_period);
        accept = wr_wid;
      end
      CMD_WR_ENABLE: begin
        wr_ena = 1'b1;
        accept = 1'b1;
      end
      CMD_RD_PERIOD: begin
        is_read = 1'b1;
        accept  = 1'b1;
        rd_val  = spk_period;
      end
      CMD_RD_WIDTH: begin
        is_read = 1'b1;
        accept  = 1'b1;
        rd_val  = spk_width;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic: a byte beats a simultaneous timeout in GET_* states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rx_done && rx_data == HDR) state_nxt = S_GET_CMD;
      S_GET_CMD: if (rx_done) state_nxt = S_GET_DH;  else if (expire) state_nxt = S_IDLE;
      S_GET_DH:  if (rx_done) state_nxt = S_GET_DL;  else if (expire) state_nxt = S_IDLE;
      S_GET_DL:  if (rx_done) state_nxt = S_GET_CHK; else if (expire) state_nxt = S_IDLE;
      S_GET_CHK: if (rx_done) state_nxt = S_EXEC;    else if (expire) state_nxt = S_IDLE;
      S_EXEC: begin
        if (!chk_ok)       state_nxt = S_IDLE;
        else if (!tx_busy) state_nxt = S_TX_WAIT;
        else               state_nxt = S_TX_LOAD;
      end
      S_TX_LOAD: if (!tx_busy) state_nxt = S_TX_WAIT;
      S_TX_WAIT: begin
        if (hold_q == 2'd0 && !tx_busy)
          state_nxt = (ridx_q < rcnt_q) ? S_TX_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; the first reply byte goes out straight from EXEC.
  always_comb begin
    cmd_d     = cmd_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    chk_d     = chk_q;
    reply_d   = reply_q;
    rcnt_d    = rcnt_q;
    ridx_d    = ridx_q;
    hold_d    = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    per_d     = spk_period;
    wid_d     = spk_width;
    ena_d     = spk_enable;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data;
    cfg_d     = 1'b0;
    err_d     = 1'b0;
    if (rx_done) begin
      case (state)
        S_GET_CMD: cmd_d = rx_data;
        S_GET_DH:  dh_d  = rx_data;
        S_GET_DL:  dl_d  = rx_data;
        S_GET_CHK: chk_d = rx_data;
        default: ;
      endcase
    end
    if (in_get && expire) err_d = 1'b1;
    if (state == S_EXEC) begin
      if (!chk_ok) begin
        err_d = 1'b1;
      end else begin
        reply_d = {rd_val[7:0], rd_val[15:8], cmd_q, first_byte};
        rcnt_d  = (accept && is_read) ? 3'd4 : 3'd2;
        ridx_d  = 3'd0;
        if (wr_per) begin
          per_d = value;
          cfg_d = (value != spk_period);
        end
        if (wr_wid) begin
          wid_d = value;
          cfg_d = (value != spk_width);
        end
        if (wr_ena) begin
          ena_d = dl_q[0];
          cfg_d = (dl_q[0] != spk_enable);
        end
      end
    end
    if (load) begin
      tx_en_d   = 1'b1;
      tx_data_d = (state == S_EXEC) ? first_byte : reply_q[ridx_q[1:0]];
      ridx_d    = ((state == S_EXEC) ? 3'd0 : ridx_q) + 3'd1;
      hold_d    = 2'd2;
    end
  end

  // Registered outputs, frame capture and reply buffer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_q      <= 8'h00;
      dh_q       <= 8'h00;
      dl_q       <= 8'h00;
      chk_q      <= 8'h00;
      reply_q    <= '0;
      rcnt_q     <= 3'd0;
      ridx_q     <= 3'd0;
      hold_q     <= 2'd0;
      spk_period <= PERIOD_RST;
      spk_width  <= WIDTH_RST;
      spk_enable <= 1'b0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      dh_q       <= dh_d;
      dl_q       <= dl_d;
      chk_q      <= chk_d;
      reply_q    <= reply_d;
      rcnt_q     <= rcnt_d;
      ridx_q     <= ridx_d;
      hold_q     <= hold_d;
      spk_period <= per_d;
      spk_width  <= wid_d;
      spk_enable <= ena_d;
      tx_en      <= tx_en_d;
      tx_data    <= tx_data_d;
      cfg_update <= cfg_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames from the feature list, then random
// frames scored against a behavioural model of the command rules. A small
// uart_send stand-in raises tx_busy for a random number of cycles per byte.
module tb_uart_cmd_ctrl;
  import ferq_pkg::*;

  localparam int FRAME_TO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        hold_busy = 1'b0;
  logic        emu_busy = 1'b0;
  logic        tx_busy;
  logic        tx_en, spk_enable, cfg_update, frame_err;
  logic [7:0]  tx_data;
  logic [15:0] spk_period, spk_width;
  state_t      dbg_state;

  assign tx_busy = hold_busy | emu_busy;

  uart_cmd_ctrl #(.CLK_FREQ(10000), .FRAME_TO(FRAME_TO)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .spk_period (spk_period),
    .spk_width  (spk_width),
    .spk_enable (spk_enable),
    .cfg_update (cfg_update),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int tx_cyc_q[$];
  int cfg_cnt = 0, err_cnt = 0, cfg_cyc = -1, err_cyc = -1;
  int exp_cfg = 0, exp_err = 0;
  int busy_left = 0, busy_len = 3, last_tx_cyc = -100;
  int last_rx_cyc = 0, chk_cyc = 0;

  // Reference model of the configuration registers.
  logic [15:0] m_per = PERIOD_RST;
  logic [15:0] m_wid = WIDTH_RST;
  logic        m_ena = 1'b0;

  function automatic void check(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endfunction

  function automatic void reply2(input logic [7:0] code, input logic [7:0] c);
    exp_q.push_back(code);
    exp_q.push_back(c);
  endfunction

  // Command rules: what the controller should answer and which register changes.
  function automatic void model_frame(input logic [7:0] c, input logic [7:0] h,
                                      input logic [7:0] l, input logic [7:0] k);
    logic [15:0] v;
    v = {h, l};
    if (k != (c ^ h ^ l)) begin
      exp_err++;
      return;
    end
    if (c == 8'h01) begin
      if (v >= 16'd2 && v > m_wid) begin
        if (v != m_per) exp_cfg++;
        m_per = v;
        reply2(8'h06, c);
      end else reply2(8'h15, c);
    end else if (c == 8'h02) begin
      if (v != 16'd0 && v < m_per) begin
        if (v != m_wid) exp_cfg++;
        m_wid = v;
        reply2(8'h06, c);
      end else reply2(8'h15, c);
    end else if (c == 8'h03) begin
      if (l[0] != m_ena) exp_cfg++;
      m_ena = l[0];
      reply2(8'h06, c);
    end else if (c == 8'h81 || c == 8'h82) begin
      reply2(8'h06, c);
      v = (c == 8'h81) ? m_per : m_wid;
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
    end else begin
      reply2(8'h15, c);
    end
  endfunction

  // uart_send stand-in and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      emu_busy = 1'b0;
      busy_left = 0;
      last_tx_cyc = -100;
    end else begin
      if (tx_en) begin
        check("tx_en_while_busy", 32'(tx_busy), 32'(0));
        if (last_tx_cyc >= 0) check("tx_en_gap", 32'((cyc - last_tx_cyc) >= 3), 32'(1));
        last_tx_cyc = cyc;
        got_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
        emu_busy = 1'b1;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) emu_busy = 1'b0;
      end
      if (cfg_update) begin
        cfg_cnt++;
        cfg_cyc = cyc;
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k);
    got_q.delete();
    exp_q.delete();
    tx_cyc_q.delete();
    model_frame(c, h, l, k);
    send_byte(HDR);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
    chk_cyc = last_rx_cyc;
  endtask

  task automatic finish_frame(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size() && !tx_busy && dbg_state == S_IDLE) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'(1));
    repeat (4) @(negedge clk);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_period"}, 32'(spk_period), 32'(m_per));
    check({tag, "_width"}, 32'(spk_width), 32'(m_wid));
    check({tag, "_enable"}, 32'(spk_enable), 32'(m_ena));
    check({tag, "_cfg_cnt"}, 32'(cfg_cnt), 32'(exp_cfg));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, 32'(tx_en), 32'(0));
    check({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    check({tag, "_period"}, 32'(spk_period), 32'(1000));
    check({tag, "_width"}, 32'(spk_width), 32'(500));
    check({tag, "_enable"}, 32'(spk_enable), 32'(0));
    check({tag, "_cfg"}, 32'(cfg_update), 32'(0));
    check({tag, "_err"}, 32'(frame_err), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int hs, rel, rxc;
    bit seen;
    logic [7:0] c, h, l, k;
    logic [15:0] v;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Read width after reset: 06 82 01 F4.
    send_frame(8'h82, 8'h00, 8'h00, 8'h82);
    finish_frame("rd_width");

    // Width 1000 is not below period 1000: NACK, width stays 500.
    send_frame(8'h02, 8'h03, 8'hE8, 8'hE9);
    finish_frame("bad_width");

    // Write period 2000: ACK, one cfg_update, first tx_en two cycles after CHK.
    send_frame(8'h01, 8'h07, 8'hD0, 8'hD6);
    finish_frame("wr_period");
    check("wr_period_tx_lat", 32'((tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1), 32'(chk_cyc + 2));
    check("wr_period_cfg_lat", 32'(cfg_cyc), 32'(chk_cyc + 2));

    // Bad checksum: frame_err two cycles after CHK, no reply, enable unchanged.
    send_frame(8'h03, 8'h00, 8'h01, 8'h00);
    finish_frame("bad_chk");
    check("bad_chk_err_lat", 32'(err_cyc), 32'(chk_cyc + 2));
    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    finish_frame("wr_enable");

    // Timeout after a partial frame, then a full frame is accepted.
    got_q.delete();
    exp_q.delete();
    send_byte(HDR);
    send_byte(8'h01);
    rxc = last_rx_cyc;
    exp_err++;
    repeat (FRAME_TO + 10) @(negedge clk);
    check("timeout_err_lat", 32'(err_cyc), 32'(rxc + FRAME_TO));
    check("timeout_state", 32'(dbg_state), 32'(S_IDLE));
    check("timeout_no_tx", 32'(got_q.size()), 32'(0));
    send_frame(8'h02, 8'h01, 8'h90, 8'h93);
    finish_frame("after_timeout");

    // tx_busy held for 50 cycles with stray bytes injected during the reply.
    busy_len = 5;
    hold_busy = 1'b1;
    hs = cyc;
    send_frame(8'h81, 8'h00, 8'h00, 8'h81);
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'($urandom));
    while (cyc < hs + 50) @(negedge clk);
    check("busy_hold_no_tx", 32'(got_q.size()), 32'(0));
    hold_busy = 1'b0;
    rel = cyc;
    send_byte(HDR);
    send_byte(HDR);
    finish_frame("busy_hold");
    check("busy_release_lat", 32'((tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1), 32'(rel + 1));

    // Reset in the middle of a reply.
    send_frame(8'h01, 8'h0B, 8'hB8, 8'hB2);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (got_q.size() >= 1) seen = 1'b1;
    end
    check("mid_reply_seen", 32'(seen), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_per = PERIOD_RST;
    m_wid = WIDTH_RST;
    m_ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Random frames biased toward the validation boundaries.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3: c = 8'h81;
        4: c = 8'h82;
        5: c = 8'($urandom);
        default: c = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
      endcase
      case ($urandom_range(0, 5))
        0: v = m_wid;
        1: v = m_wid + 16'd1;
        2: v = m_per;
        3: v = m_per - 16'd1;
        4: v = 16'($urandom_range(0, 3));
        default: v = 16'($urandom_range(0, 4000));
      endcase
      h = v[15:8];
      l = v[7:0];
      k = c ^ h ^ l;
      if ($urandom_range(0, 7) == 0) k = k ^ 8'($urandom_range(1, 255));
      busy_len = $urandom_range(1, 12);
      send_frame(c, h, l, k);
      finish_frame("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
